aes_key_schedule: RTL and testbench
===================================

# aes_key_schedule

Sequential, parametrised AES key schedule supporting AES-128, AES-192 and AES-256. It generates one 32-bit schedule word per clock into an internal round-key store and then serves 128-bit round keys through a registered read port. It replaces the fully unrolled AES-128-only key expansion in the cipher datapath, trading latency for about one-tenth of the S-box count.

## Interface
- MAX_KEY_BITS, 256: largest key size supported (128, 192 or 256). Sets store depth to 44, 52 or 60 words.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request to begin an expansion; sampled only in IDLE.
- key_len  in  2  0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = reserved.
- key_in  in  256  cipher key, left-justified; a 128-bit key occupies [255:128].
- busy  out  1  high in LOAD/EXPAND.
- done  out  1  one-cycle pulse at completion.
- err  out  1  one-cycle pulse, coincident with done, when key_len is unsupported.
- key_valid  out  1  level; the schedule in the store is complete.
- rd_en  in  1  read request.
- rd_round  in  4  round index, 0..Nr.
- rd_valid  out  1  registered; read data valid.
- rd_key  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.

## Operation
- Nk / Nr: key_len 0 → 4/10, 1 → 6/12, 2 → 8/14. Total words T = 4·(Nr+1) = 44/52/60.
- FSM states: IDLE, EXPAND, DONE.
- IDLE with start=1 and a supported key_len:
  - capture Nk, clear key_valid;
  - write w[0..Nk-1] from key_in;
  - set i=Nk, j=0 (j = i mod Nk), rcon=0x01;
  - go to EXPAND.
- IDLE with start=1 and key_len=3, or key_len > MAX_KEY_BITS: go to DONE with err; the store is untouched and key_valid=0.
- EXPAND writes one word per cycle:
  - temp = w[i-1];
  - if j==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon ← xtime(rcon);
  - else if Nk==8 and j==4: temp = SubWord(temp);
  - w[i] = w[i-Nk] ^ temp;
  - i++, j wraps at Nk.
  - After writing w[T-1], go to DONE.
- Word lookup uses counters and an Nk-deep window, never a divider.
- xtime(x) = (x<<1) ^ (x[7] ? 8'h1B : 0).
- DONE, for one cycle: done=1. key_valid=1 unless err. Then go to IDLE.
- start while busy: ignored.
- Read port, usable in any state:
  - rd_en at edge E gives rd_valid=1 at E+1 only if key_valid and rd_round ≤ Nr;
  - otherwise rd_valid=0 and rd_key=0.
- Reset (including mid-expansion): IDLE, busy=0, done=0, err=0, key_valid=0, rd_valid=0, rd_key=0.

## Timing
- Start-accept edge T0 writes words 0..Nk-1.
- Last word is written at edge T0+N, with N = 40 / 46 / 52.
- done and key_valid are high in the cycle after edge T0+N. Start-to-done is 41/47/53 edges.
- The err path: done/err are high in the cycle after T0.
- A new start is accepted at the earliest on the edge after done. key_valid falls on that accepting edge.
- Read latency is 1 cycle; back-to-back reads are supported every cycle.

## Configuration
- AES_KS_ZEROIZE_EN defined:
  - adds input port zeroize (1 bit);
  - zeroize=1 in any state clears every store word, clears key_valid and returns to IDLE in one cycle, with priority over start;
  - rst_n also clears the store.
- Undefined: no zeroize port, and the store has no reset (control state only).

## Structure
- aes_pkg holds:
  - key_len encodings;
  - the nk_of/nr_of functions;
  - the xtime function;
  - the FSM state enum;
  - the 8'h1B reduction constant.
- Sub-module aes_ks_word: combinational RotWord/SubWord/Rcon step using four aes_sbox instances. Selects are rot_en and sub_en.
- Store: register array of depth 4·(MAX_KEY_BITS/32+7).

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start → done 41 cycles later; read round 10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → done after 47 cycles; round 12 → e98ba06f448c773c8ecc720401002202; rd_round=13 → rd_valid=0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → done after 53 cycles; round 14 → fe4890d1e6188d0b046df344706c631e; round 0 → 603deb1015ca71be2b73aef0857d7781.
- key_len=3 → done and err pulse together one cycle after start; key_valid stays 0; reads return rd_valid=0.
- rst_n pulsed low at cycle 20 of an AES-256 run → all outputs at reset values. A fresh AES-128 run then matches the vector; start asserted during busy is ignored.
- (AES_KS_ZEROIZE_EN) zeroize after a completed run → key_valid=0 next cycle. After a dummy start with key_len=3, the store reads as 0 via a debug peek.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the sequential AES key schedule: key-length encodings,
// Nk/Nr lookup, GF(2^8) doubling and the controller state encoding.
package aes_pkg;

    localparam logic [1:0] KEY_LEN_128  = 2'd0;
    localparam logic [1:0] KEY_LEN_192  = 2'd1;
    localparam logic [1:0] KEY_LEN_256  = 2'd2;
    localparam logic [1:0] KEY_LEN_RSVD = 2'd3;

    // AES field polynomial x^8 + x^4 + x^3 + x + 1, low byte
    localparam logic [7:0] XTIME_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } ks_state_e;

    function automatic logic [3:0] nk_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: nk_of = 4'd4;
            KEY_LEN_192: nk_of = 4'd6;
            default:     nk_of = 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: nr_of = 4'd10;
            KEY_LEN_192: nr_of = 4'd12;
            default:     nr_of = 4'd14;
        endcase
    endfunction

    function automatic int key_bits_of(input logic [1:0] key_len);
        return 128 + 64 * int'(key_len);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Request/response bundle of the key schedule: expansion control plus the
// round-key read port. The controller uses the slave view.
interface aes_key_schedule_if;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         err;
    logic         key_valid;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic         rd_valid;
    logic [127:0] rd_key;

    modport master (
        output start, key_len, key_in, rd_en, rd_round,
        input  busy, done, err, key_valid, rd_valid, rd_key
    );

    modport slave (
        input  start, key_len, key_in, rd_en, rd_round,
        output busy, done, err, key_valid, rd_valid, rd_key
    );
endinterface

// File: rtl/aes_ks_word.sv
// One key-schedule word transform: optional RotWord, optional SubWord through
// four S-boxes, and the round constant folded in only with the rotation.
module aes_ks_word (
    input  logic [31:0] word_in,
    input  logic [7:0]  rcon,
    input  logic        rot_en,
    input  logic        sub_en,
    output logic [31:0] word_out
);
    logic [31:0] rot_word;
    logic [31:0] sub_word;

    // byte rotate left: {a0,a1,a2,a3} -> {a1,a2,a3,a0}
    always_comb rot_word = rot_en ? {word_in[23:0], word_in[31:24]} : word_in;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_word[8*b +: 8]),
            .out_byte (sub_word[8*b +: 8])
        );
    end

    // select substituted word, adding rcon to the top byte on rotation steps
    always_comb begin
        word_out = rot_word;
        if (sub_en) begin
            word_out = sub_word ^ {(rot_en ? rcon : 8'h00), 24'h000000};
        end
    end
endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box as a constant lookup table (entry 0 in the top byte).
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // entry n sits at bit offset 8*(255-n), i.e. {~n, 3'b000}
    always_comb out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];
endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128/192/256 key schedule: one schedule word per clock into a
// round-key store, served as 128-bit round keys on a registered read port.
// Optional build macro: AES_KS_ZEROIZE_EN adds a zeroize input that wipes the
// store and window and lets rst_n clear them too; without it only control
// state is reset.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for start; key words w[0..Nk-1] written on accept
// ST_EXPAND | writing w[i] one per cycle until w[4*(Nr+1)-1]
// ST_DONE   | one-cycle done pulse (with err if the key length was refused)
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic clk,
    input  logic rst_n,
`ifdef AES_KS_ZEROIZE_EN
    input  logic zeroize,
`endif
    aes_key_schedule_if.slave ks_if
);
    localparam int STORE_DEPTH = 4 * (MAX_KEY_BITS / 32 + 7);

    ks_state_e    state_q, state_d;
    logic [5:0]   i_q, i_d;
    logic [2:0]   j_q, j_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   nk_q, nk_d;
    logic [3:0]   nr_q, nr_d;
    logic         key_valid_q, key_valid_d;
    logic         err_q, err_d;
    logic         rd_valid_q, rd_valid_d;
    logic [127:0] rd_key_q, rd_key_d;

    logic [31:0]  store_q [STORE_DEPTH];
    logic [31:0]  store_d [STORE_DEPTH];
    // win[0] = w[i-1] ... win[Nk-1] = w[i-Nk]; avoids any i mod Nk arithmetic
    logic [31:0]  win_q [8];
    logic [31:0]  win_d [8];

    logic         key_ok;
    logic         rot_en;
    logic         sub_en;
    logic [31:0]  step_word;
    logic [31:0]  new_word;
    logic [5:0]   last_idx;
    logic [5:0]   rd_base;

    aes_ks_word u_word (
        .word_in  (win_q[0]),
        .rcon     (rcon_q),
        .rot_en   (rot_en),
        .sub_en   (sub_en),
        .word_out (step_word)
    );

    // schedule step selection and the new word w[i] = w[i-Nk] ^ temp
    always_comb begin
        key_ok   = (ks_if.key_len != KEY_LEN_RSVD) &&
                   (key_bits_of(ks_if.key_len) <= MAX_KEY_BITS);
        rot_en   = (j_q == 3'd0);
        sub_en   = (j_q == 3'd0) || ((nk_q == 4'd8) && (j_q == 3'd4));
        new_word = win_q[3'(nk_q - 4'd1)] ^ step_word;
        last_idx = {nr_q + 4'd1, 2'b00} - 6'd1;
    end

    // FSM next state, counters, store and window updates
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        rcon_d      = rcon_q;
        nk_d        = nk_q;
        nr_d        = nr_q;
        key_valid_d = key_valid_q;
        err_d       = 1'b0;
        store_d     = store_q;
        win_d       = win_q;

        case (state_q)
            ST_IDLE: begin
                if (ks_if.start) begin
                    key_valid_d = 1'b0;
                    if (key_ok) begin
                        nk_d = nk_of(ks_if.key_len);
                        nr_d = nr_of(ks_if.key_len);
                        for (int k = 0; k < 8; k++) begin
                            if (k < int'(nk_d)) begin
                                store_d[k] = ks_if.key_in[(7 - k) * 32 +: 32];
                                win_d[k]   = ks_if.key_in[(8 - int'(nk_d) + k) * 32 +: 32];
                            end
                        end
                        i_d     = {2'b00, nk_d};
                        j_d     = 3'd0;
                        rcon_d  = 8'h01;
                        state_d = ST_EXPAND;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_EXPAND: begin
                store_d[i_q] = new_word;
                win_d[0]     = new_word;
                for (int k = 1; k < 8; k++) begin
                    win_d[k] = win_q[k - 1];
                end
                i_d = i_q + 6'd1;
                j_d = ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
                if (j_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == last_idx) begin
                    key_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef AES_KS_ZEROIZE_EN
        if (zeroize) begin
            state_d     = ST_IDLE;
            key_valid_d = 1'b0;
            err_d       = 1'b0;
            i_d         = '0;
            j_d         = '0;
            rcon_d      = '0;
            for (int k = 0; k < STORE_DEPTH; k++) begin
                store_d[k] = '0;
            end
            for (int k = 0; k < 8; k++) begin
                win_d[k] = '0;
            end
        end
`endif
    end

    // read port: valid only for a complete schedule and an existing round
    always_comb begin
        rd_base    = {ks_if.rd_round, 2'b00};
        rd_valid_d = ks_if.rd_en && key_valid_q && (ks_if.rd_round <= nr_q);
        rd_key_d   = '0;
        if (rd_valid_d) begin
            rd_key_d = {store_q[rd_base], store_q[rd_base + 6'd1],
                        store_q[rd_base + 6'd2], store_q[rd_base + 6'd3]};
        end
    end

    // control state and read-port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            rcon_q      <= '0;
            nk_q        <= '0;
            nr_q        <= '0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_key_q    <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            rcon_q      <= rcon_d;
            nk_q        <= nk_d;
            nr_q        <= nr_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
            rd_valid_q  <= rd_valid_d;
            rd_key_q    <= rd_key_d;
        end
    end

`ifdef AES_KS_ZEROIZE_EN
    // key material registers, wiped by reset in the zeroize build
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STORE_DEPTH; k++) begin
                store_q[k] <= '0;
            end
            for (int k = 0; k < 8; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            store_q <= store_d;
            win_q   <= win_d;
        end
    end
`else
    // key material registers, no reset
    always_ff @(posedge clk) begin
        store_q <= store_d;
        win_q   <= win_d;
    end
`endif

    assign ks_if.busy      = (state_q == ST_EXPAND);
    assign ks_if.done      = (state_q == ST_DONE);
    assign ks_if.err       = err_q;
    assign ks_if.key_valid = key_valid_q;
    assign ks_if.rd_valid  = rd_valid_q;
    assign ks_if.rd_key    = rd_key_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using FIPS-197 expansion vectors.
module tb_aes_key_schedule;

    typedef struct {
        logic [1:0]   len;
        logic [255:0] key;
        int           edges;
        logic         err;
    } run_vec_t;

    typedef struct {
        int           set;
        logic [3:0]   rnd;
        logic         vld;
        logic [127:0] key;
    } rd_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_schedule_if ks_if ();
`ifdef AES_KS_ZEROIZE_EN
    logic zeroize = 1'b0;
`endif

    aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef AES_KS_ZEROIZE_EN
        .zeroize (zeroize),
`endif
        .ks_if   (ks_if)
    );

    int checks = 0;
    int errors = 0;

    run_vec_t run_tab [4];
    rd_vec_t  rd_tab  [14];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {250'd0, ks_if.busy, ks_if.done, ks_if.err, ks_if.key_valid,
                   ks_if.rd_valid, |ks_if.rd_key}, 256'd0);
        chk({name, " rd_key"}, {128'd0, ks_if.rd_key}, 256'd0);
    endtask

    task automatic run_expand(input string name, input run_vec_t v, input bit poke);
        int cnt;
        @(negedge clk);
        ks_if.start   = 1'b1;
        ks_if.key_len = v.len;
        ks_if.key_in  = v.key;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                chk({name, " busy after accept"}, 256'(ks_if.busy), 256'(!v.err));
                chk({name, " key_valid cleared"}, 256'(ks_if.key_valid), 256'd0);
            end
            ks_if.start = poke && (cnt == 5);
            if (poke && cnt == 5) begin
                ks_if.key_len = 2'd2;
                ks_if.key_in  = ~v.key;
            end
        end while (!ks_if.done && cnt < 200);
        chk({name, " start-to-done edges"}, 256'(cnt), 256'(v.edges));
        chk({name, " err at done"}, 256'(ks_if.err), 256'(v.err));
        chk({name, " key_valid at done"}, 256'(ks_if.key_valid), 256'(!v.err));
        ks_if.start = 1'b0;
        @(negedge clk);
        chk({name, " done pulse ends"}, 256'({ks_if.done, ks_if.err}), 256'd0);
    endtask

    task automatic run_reads(input int set);
        bit      pend;
        rd_vec_t p;
        pend = 1'b0;
        foreach (rd_tab[n]) begin
            if (rd_tab[n].set == set) begin
                @(negedge clk);
                if (pend) check_read(p);
                ks_if.rd_en    = 1'b1;
                ks_if.rd_round = rd_tab[n].rnd;
                p    = rd_tab[n];
                pend = 1'b1;
            end
        end
        @(negedge clk);
        if (pend) check_read(p);
        ks_if.rd_en = 1'b0;
    endtask

    task automatic check_read(input rd_vec_t p);
        chk($sformatf("read set%0d round%0d valid", p.set, p.rnd), 256'(ks_if.rd_valid), 256'(p.vld));
        chk($sformatf("read set%0d round%0d key", p.set, p.rnd), {128'd0, ks_if.rd_key}, {128'd0, p.key});
    endtask

    initial begin
        run_tab[0] = '{2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0}, 41, 1'b0};
        run_tab[1] = '{2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'd0}, 47, 1'b0};
        run_tab[2] = '{2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 53, 1'b0};
        run_tab[3] = '{2'd3, 256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef, 1, 1'b1};

        rd_tab[0]  = '{0, 4'd0,  1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c};
        rd_tab[1]  = '{0, 4'd1,  1'b1, 128'ha0fafe1788542cb123a339392a6c7605};
        rd_tab[2]  = '{0, 4'd2,  1'b1, 128'hf2c295f27a96b9435935807a7359f67f};
        rd_tab[3]  = '{0, 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        rd_tab[4]  = '{0, 4'd11, 1'b0, 128'd0};
        rd_tab[5]  = '{1, 4'd1,  1'b1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5};
        rd_tab[6]  = '{1, 4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202};
        rd_tab[7]  = '{1, 4'd13, 1'b0, 128'd0};
        rd_tab[8]  = '{2, 4'd0,  1'b1, 128'h603deb1015ca71be2b73aef0857d7781};
        rd_tab[9]  = '{2, 4'd1,  1'b1, 128'h1f352c073b6108d72d9810a30914dff4};
        rd_tab[10] = '{2, 4'd2,  1'b1, 128'h9ba354118e6925afa51a8b5f2067fcde};
        rd_tab[11] = '{2, 4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e};
        rd_tab[12] = '{2, 4'd15, 1'b0, 128'd0};
        rd_tab[13] = '{3, 4'd0,  1'b0, 128'd0};

        ks_if.start    = 1'b0;
        ks_if.key_len  = 2'd0;
        ks_if.key_in   = '0;
        ks_if.rd_en    = 1'b0;
        ks_if.rd_round = 4'd0;

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset state");
        rst_n = 1'b1;

        // normal expansions plus a read sweep after each
        for (int s = 0; s < 4; s++) begin
            run_expand($sformatf("run%0d", s), run_tab[s], 1'b0);
            run_reads(s);
        end

        // reset in the middle of an AES-256 expansion
        @(negedge clk);
        ks_if.start   = 1'b1;
        ks_if.key_len = run_tab[2].len;
        ks_if.key_in  = run_tab[2].key;
        @(negedge clk);
        ks_if.start = 1'b0;
        ks_if.rd_en = 1'b1;
        repeat (19) @(negedge clk);
        chk("busy before mid-run reset", 256'(ks_if.busy), 256'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid-run reset");
        @(negedge clk);
        ks_if.rd_en = 1'b0;
        rst_n = 1'b1;

        // fresh AES-128 with a start pulse injected while busy
        run_expand("run0 after reset", run_tab[0], 1'b1);
        run_reads(0);

`ifdef AES_KS_ZEROIZE_EN
        begin : zeroize_seq
            logic [31:0] acc;
            @(negedge clk);
            zeroize = 1'b1;
            @(negedge clk);
            zeroize = 1'b0;
            chk("zeroize key_valid", 256'(ks_if.key_valid), 256'd0);
            run_expand("dummy after zeroize", run_tab[3], 1'b0);
            acc = '0;
            for (int k = 0; k < 60; k++) begin
                acc = acc | dut.store_q[k];
            end
            chk("zeroize store peek", 256'(acc), 256'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
